// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Op codes follow the funct-derived 2-bit selector used by the execute stage.
package mips_muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULTU = 2'd0,
        MD_MULT  = 2'd1,
        MD_DIVU  = 2'd2,
        MD_DIV   = 2'd3
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

    // Wide enough for any supported DATA_WIDTH; consumers slice the low bits.
    localparam int MD_MAX_WIDTH = 64;
    localparam logic [MD_MAX_WIDTH-1:0] MD_QUOT_ALL_ONES = '1;

    function automatic logic op_is_div(input md_op_t o);
        return (o == MD_DIVU) || (o == MD_DIV);
    endfunction

    function automatic logic op_is_signed(input md_op_t o);
        return (o == MD_MULT) || (o == MD_DIV);
    endfunction

endpackage

// File: rtl/mips_muldiv_unit_sign_fix.sv
// Sign handling around the unsigned iterative core: operand magnitudes on the way in,
// result negation on the way out (one negator for HI, one for LO; HI borrows LO's carry for products).
module muldiv_sign_fix
    import mips_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  is_signed,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] abs_a,
    output logic [DATA_WIDTH-1:0] abs_b,
    output logic                  a_neg,
    output logic                  b_neg,
    input  logic                  is_mul,
    input  logic                  neg_hi,
    input  logic                  neg_lo,
    input  logic [DATA_WIDTH-1:0] raw_hi,
    input  logic [DATA_WIDTH-1:0] raw_lo,
    output logic [DATA_WIDTH-1:0] fix_hi,
    output logic [DATA_WIDTH-1:0] fix_lo
);

    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    logic                  hi_cin;
    logic [DATA_WIDTH-1:0] hi_negated;
    logic [DATA_WIDTH-1:0] lo_negated;

    assign a_neg = is_signed & a[DATA_WIDTH-1];
    assign b_neg = is_signed & b[DATA_WIDTH-1];
    assign abs_a = a_neg ? (~a + ONE) : a;
    assign abs_b = b_neg ? (~b + ONE) : b;

    // A product is negated as one 2N-bit value; a remainder is negated on its own.
    assign hi_cin     = is_mul ? (raw_lo == '0) : 1'b1;
    assign hi_negated = ~raw_hi + {{(DATA_WIDTH-1){1'b0}}, hi_cin};
    assign lo_negated = ~raw_lo + ONE;

    assign fix_hi = neg_hi ? hi_negated : raw_hi;
    assign fix_lo = neg_lo ? lo_negated : raw_lo;

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative HI/LO multiply/divide: shift-add multiply and restoring divide, one bit per clock.
// Result lands DATA_WIDTH+2 cycles after start; starts while busy are dropped, not queued.
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter  int DATA_WIDTH  = 32,
    localparam int COUNT_WIDTH = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  hiWrite,
    input  logic                  loWrite,
    output logic                  busy,
    output logic                  done,
    output logic                  divByZero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    md_state_t              state_q, state_d;
    md_op_t                 op_in, op_q;
    logic                   in_div;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   last_iter;
    logic [DATA_WIDTH-1:0]  acc_hi_q, acc_lo_q, operand_q;
    logic                   neg_hi_q, neg_lo_q, zero_div_q;
    logic [DATA_WIDTH-1:0]  hi_q, lo_q;
    logic                   done_q, dbz_q;

    logic [DATA_WIDTH-1:0]  abs_a, abs_b, fix_hi, fix_lo;
    logic                   a_neg, b_neg;

    logic [DATA_WIDTH:0]    mul_sum;
    logic [DATA_WIDTH:0]    div_shift;
    logic [DATA_WIDTH-1:0]  div_trial;
    logic                   div_fits;

    assign op_in     = md_op_t'(op);
    assign in_div    = op_is_div(op_in);
    assign last_iter = (count_q == COUNT_WIDTH'(DATA_WIDTH - 1));

    muldiv_sign_fix #(.DATA_WIDTH(DATA_WIDTH)) u_sign_fix (
        .is_signed (op_is_signed(op_in)),
        .a         (a),
        .b         (b),
        .abs_a     (abs_a),
        .abs_b     (abs_b),
        .a_neg     (a_neg),
        .b_neg     (b_neg),
        .is_mul    (!op_is_div(op_q)),
        .neg_hi    (neg_hi_q),
        .neg_lo    (neg_lo_q),
        .raw_hi    (acc_hi_q),
        .raw_lo    (acc_lo_q),
        .fix_hi    (fix_hi),
        .fix_lo    (fix_lo)
    );

    // acc_hi: partial product high half / partial remainder.
    // acc_lo: multiplier shifting out / dividend shifting out while quotient shifts in.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, operand_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[DATA_WIDTH-1]};
        div_fits  = (div_shift >= {1'b0, operand_q});
        div_trial = div_shift[DATA_WIDTH-1:0] - operand_q;
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= MD_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (start) state_d = MD_RUN;
            MD_RUN:  if (last_iter) state_d = MD_FIX;
            MD_FIX:  state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q       <= MD_MULTU;
            count_q    <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            operand_q  <= '0;
            neg_hi_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            zero_div_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MD_IDLE: begin
                    if (hiWrite) hi_q <= a;
                    if (loWrite) lo_q <= a;
                    if (start) begin
                        op_q       <= op_in;
                        count_q    <= '0;
                        acc_hi_q   <= '0;
                        acc_lo_q   <= in_div ? abs_a : abs_b;
                        operand_q  <= in_div ? abs_b : abs_a;
                        neg_lo_q   <= a_neg ^ b_neg;
                        // Remainder follows the dividend; product follows the combined sign.
                        neg_hi_q   <= in_div ? a_neg : (a_neg ^ b_neg);
                        zero_div_q <= in_div && (b == '0);
                        dbz_q      <= 1'b0;
                    end
                end
                MD_RUN: begin
                    count_q <= last_iter ? '0 : count_q + COUNT_WIDTH'(1);
                    if (op_is_div(op_q)) begin
                        acc_hi_q <= div_fits ? div_trial : div_shift[DATA_WIDTH-1:0];
                        acc_lo_q <= {acc_lo_q[DATA_WIDTH-2:0], div_fits};
                    end else begin
                        acc_hi_q <= mul_sum[DATA_WIDTH:1];
                        acc_lo_q <= {mul_sum[0], acc_lo_q[DATA_WIDTH-1:1]};
                    end
                end
                MD_FIX: begin
                    // Divide-by-zero: the core already leaves |a| as remainder, so
                    // sign fix restores a; only the quotient needs forcing.
                    hi_q   <= fix_hi;
                    lo_q   <= zero_div_q ? MD_QUOT_ALL_ONES[DATA_WIDTH-1:0] : fix_lo;
                    done_q <= 1'b1;
                    dbz_q  <= zero_div_q;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q != MD_IDLE);
    assign done      = done_q;
    assign divByZero = dbz_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Randomized and directed bench for mips_muldiv_unit against a cycle-level arithmetic reference.
module tb_mips_muldiv_unit;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a, b;
    logic          hiWrite, loWrite;
    logic          busy, done, divByZero;
    logic [W-1:0]  hi, lo;

    int checks = 0;
    int errors = 0;

    mips_muldiv_unit #(.DATA_WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .hiWrite   (hiWrite),
        .loWrite   (loWrite),
        .busy      (busy),
        .done      (done),
        .divByZero (divByZero),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, straight from MIPS semantics.
    task automatic ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] rh, output logic [31:0] rl, output logic rz);
        longint unsigned pu;
        longint          ps;
        int              sx, sy;
        rz = 1'b0;
        rh = '0;
        rl = '0;
        case (o)
            2'd0: begin
                pu = longint'({32'b0, x}) * longint'({32'b0, y});
                rh = pu[63:32];
                rl = pu[31:0];
            end
            2'd1: begin
                ps = longint'($signed(x)) * longint'($signed(y));
                rh = ps[63:32];
                rl = ps[31:0];
            end
            default: begin
                if (y == 0) begin
                    rl = 32'hFFFF_FFFF;
                    rh = x;
                    rz = 1'b1;
                end else if (o == 2'd2) begin
                    rl = x / y;
                    rh = x % y;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    rl = x;
                    rh = '0;
                end else begin
                    sx = $signed(x);
                    sy = $signed(y);
                    rl = sx / sy;
                    rh = sx % sy;
                end
            end
        endcase
    endtask

    // Cycle-level reference: m_rem counts the busy cycles still to come.
    int          m_rem = 0;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        m_done, m_dbz, p_dbz;
    logic        m_valid = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_rem = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_dbz = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            m_done = 1'b0;
            if (m_rem != 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz; m_done = 1'b1;
                end
            end else begin
                if (hiWrite) m_hi = a;
                if (loWrite) m_lo = a;
                if (start) begin
                    ref_op(op, a, b, p_hi, p_lo, p_dbz);
                    m_rem = W + 1;
                    m_dbz = 1'b0;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            chk("busy", 32'(busy), 32'(m_rem != 0));
            chk("done", 32'(done), 32'(m_done));
            chk("divByZero", 32'(divByZero), 32'(m_dbz));
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit now, input logic hw, input logic lw);
        if (!now) @(negedge clock);
        start = 1'b1; op = o; a = x; b = y; hiWrite = hw; loWrite = lw;
        @(negedge clock);
        start = 1'b0; hiWrite = 1'b0; loWrite = 1'b0;
    endtask

    // Called in cycle 1 after launch; n is the cycle index at which done is seen.
    task automatic wait_done(output int n);
        n = 1;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0; hiWrite = 1'b0; loWrite = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_dbz", 32'(divByZero), 32'd0);

        // MULT -3 * 7, with latency and busy window
        launch(2'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, 1'b0);
        chk("mult_busy_c1", 32'(busy), 32'd1);
        wait_done(n);
        chk("mult_latency", 32'(n), 32'd34);
        chk("mult_busy_done", 32'(busy), 32'd0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFEB);

        // MULTU max*max, launched in the done cycle
        launch(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        wait_done(n);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);

        launch(2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0);
        wait_done(n);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);

        launch(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        wait_done(n);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'h0);

        launch(2'd2, 32'h1234, 32'h0, 1'b0, 1'b0, 1'b0);
        wait_done(n);
        chk("dbz_lo", lo, 32'hFFFF_FFFF);
        chk("dbz_hi", hi, 32'h1234);
        chk("dbz_flag", 32'(divByZero), 32'd1);
        repeat (3) @(negedge clock);
        chk("dbz_held", 32'(divByZero), 32'd1);
        launch(2'd0, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        chk("dbz_cleared", 32'(divByZero), 32'd0);
        wait_done(n);

        // DIVU 100/7 with an ignored restart and an ignored MTLO while busy
        launch(2'd2, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clock);
        start = 1'b1; op = 2'd0; a = 32'd2; b = 32'd3;
        @(negedge clock);
        start = 1'b0; loWrite = 1'b1; a = 32'h55;
        @(negedge clock);
        loWrite = 1'b0;
        wait_done(n);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);
        @(negedge clock);
        loWrite = 1'b1; a = 32'h55;
        @(negedge clock);
        loWrite = 1'b0;
        chk("mtlo_lo", lo, 32'h55);
        chk("mtlo_hi", hi, 32'd2);

        // Reset mid-operation
        launch(2'd1, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        repeat (40) begin
            @(negedge clock);
            if (done !== 1'b0) chk("abort_no_done", 32'(done), 32'd0);
        end
        launch(2'd1, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0);
        wait_done(n);
        chk("after_abort_lo", lo, 32'd25);
        chk("after_abort_hi", hi, 32'd0);

        // Randomized traffic: idle MTHI/MTLO, writes alongside start, junk while busy
        for (int i = 0; i < 40; i++) begin
            int guard;
            bit now;
            now = ($urandom_range(0, 1) == 1);
            if (!now) begin
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clock);
                    hiWrite = ($urandom_range(0, 2) == 0);
                    loWrite = ($urandom_range(0, 2) == 0);
                    a = $urandom;
                end
            end
            launch(2'($urandom_range(0, 3)), pick(), pick(), now,
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            guard = 0;
            while (m_rem != 0 && guard < 200) begin
                start   = ($urandom_range(0, 3) == 0);
                op      = 2'($urandom_range(0, 3));
                a       = $urandom;
                b       = $urandom;
                hiWrite = ($urandom_range(0, 3) == 0);
                loWrite = ($urandom_range(0, 3) == 0);
                @(negedge clock);
                guard++;
            end
            start = 1'b0; hiWrite = 1'b0; loWrite = 1'b0;
            if (guard >= 200) chk("rand_timeout", 32'(m_rem), 32'd0);
        end

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
Multi-cycle MIPS HI/LO multiply/divide unit that sits beside the single-cycle ALU in the execute stage. It handles MULT, MULTU, DIV and DIVU, one iteration per clock, and keeps its results in internal HI/LO registers. It also handles MTHI/MTLO writes. It uses a start/busy/done handshake so the pipeline can stall on MFHI/MFLO while an operation is in flight.

Parameters:
DATA_WIDTH, 32, operand width and width of each of HI and LO; must be at least 4.
COUNT_WIDTH, $clog2(DATA_WIDTH)+1, width of the iteration counter; derived, not overridden.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  launch op with operands a/b; sampled only in IDLE
op  input  2  0=MULTU, 1=MULT, 2=DIVU, 3=DIV
a  input  DATA_WIDTH  multiplicand / dividend
b  input  DATA_WIDTH  multiplier / divisor
hiWrite  input  1  MTHI: hi <= a
loWrite  input  1  MTLO: lo <= a
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse; hi/lo hold the new result in the same cycle
divByZero  output  1  sticky until next start; set when a DIV/DIVU ran with b==0
hi  output  DATA_WIDTH  HI register: product upper half / remainder
lo  output  DATA_WIDTH  LO register: product lower half / quotient

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high. Reset has priority over every other input.
- Reset values: state=IDLE, busy=0, done=0, divByZero=0, hi=0, lo=0, counter=0.
- States and transitions:
  - IDLE: on start=1, latch op and |a|,|b| (absolute values for signed ops, raw values for unsigned). Record the result signs. Clear the accumulator and clear divByZero. Go to RUN; busy=1 from the next cycle.
  - RUN: lasts exactly DATA_WIDTH cycles. The counter counts 0..DATA_WIDTH-1.
    - Multiply: shift-add, one multiplier bit per cycle, into a 2*DATA_WIDTH-bit accumulator.
    - Divide: restoring division, one quotient bit per cycle.
  - FIX: one cycle. Apply sign correction and write hi/lo. Assert done (registered) in the following cycle. Return to IDLE; busy=0 in the same cycle done=1.
- Latency: with start sampled at edge 0, done=1 and the new hi/lo are visible in cycle DATA_WIDTH+2. busy is high for cycles 1..DATA_WIDTH+1.
- Start rules:
  - start while busy=1 is ignored; no queueing.
  - start in the same cycle done=1 is accepted, because the state is IDLE then.
- Signed rules:
  - MULT: 2*DATA_WIDTH-bit two's-complement product.
  - DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIV with MIN / -1: lo=MIN, hi=0. No trap.
- Divide by zero (DIV or DIVU with b==0):
  - Still runs the full latency.
  - Results: lo=all ones, hi=a.
  - divByZero=1 in the done cycle, held until the next accepted start or reset.
- MTHI/MTLO:
  - Take effect at the next edge only when busy=0 and the unit is not in FIX.
  - Ignored while busy.
  - If hiWrite/loWrite coincides with start, the register write happens and the op is also launched; the op's result overwrites it later.
- hi/lo hold their values at all other times. Reading during busy returns the previous values; stalling is the pipeline's job.
- Reset mid-operation: abort. Next cycle is IDLE, busy=0, no done pulse, hi/lo=0.

Decomposition:
- Package mips_muldiv_pkg:
  - op encodings MD_MULTU, MD_MULT, MD_DIVU, MD_DIV.
  - State encoding MD_IDLE, MD_RUN, MD_FIX.
  - Helper constant for the all-ones quotient.
- One sub-module, muldiv_sign_fix: combinational. It computes the operand absolute values and the output negation, sharing one negate for hi/lo each.
- The FSM, counter and accumulator stay in the top module.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> done at cycle 34 after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high cycles 1..33.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234, divByZero=1. Next start clears divByZero.
- Start DIVU 100/7, re-assert start with MULTU 2*3 at cycle 5, and pulse loWrite a=0x55 at cycle 6 -> both ignored; result lo=14, hi=2. Then loWrite a=0x55 in IDLE -> lo=0x55, hi unchanged.
- Start MULT 5*5, assert reset at cycle 10 -> next cycle busy=0, hi=lo=0, no done pulse. A new start afterwards completes normally with lo=25.
